// File: rtl/audio_i2s_receiver.sv
// audio_i2s_receiver
// Oversampling receiver for the left-justified stereo serial audio link.
// BCK, WS and DATA are synchronised into clk, BCK rising edges are detected,
// and each half-frame is deserialised MSB first. A right word is parked
// until the following left word completes; the pair is then presented
// together with a one-cycle sample_valid strobe. A half-frame that ends
// before WIDTH bits arrive is reported with a one-cycle frame_err strobe.

module audio_i2s_receiver #(
    parameter int WIDTH         = 16,
    parameter int SLOTS_PER_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_BCK,
    input  logic             audio_WS,
    input  logic             audio_DATA,
    output logic [WIDTH-1:0] audio_out_left,
    output logic [WIDTH-1:0] audio_out_right,
    output logic             sample_valid,
    output logic             frame_err
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int SW = (SLOTS_PER_BIT > 1) ? $clog2(SLOTS_PER_BIT) : 1;

    localparam logic [BW-1:0] BIT_FULL  = BW'(WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS_PER_BIT - 1);

    // Synchroniser stages; r_bck_s3 is the previous value of r_bck_s2.
    logic r_bck_s1, r_bck_s2, r_bck_s3;
    logic r_ws_s1, r_ws_s2;
    logic r_data_s1, r_data_s2;

    // Bit-level deserialiser state.
    logic             r_ws_ref_ok;   // r_ws_prev holds a real sampled WS
    logic             r_ws_prev;
    logic             r_locked;
    logic [SW-1:0]    r_slot_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic             r_word_done;
    logic             r_word_left;
    logic             r_short;

    // Word-level pairing state.
    logic [WIDTH-1:0] r_right_hold;
    logic             r_right_ok;

    logic             w_bck_rise;
    logic             w_ws_edge;
    logic             w_active;
    logic             w_finish_old;
    logic [SW-1:0]    w_slot_base;
    logic [BW-1:0]    w_bit_base;
    logic             w_capture;
    logic             w_complete;
    logic             w_short;
    logic [SW-1:0]    w_slot_next;
    logic [BW-1:0]    w_bit_next;

    // Two-flop synchronisers with equal delay on all three lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bck_s1  <= 1'b0;
            r_bck_s2  <= 1'b0;
            r_bck_s3  <= 1'b0;
            r_ws_s1   <= 1'b0;
            r_ws_s2   <= 1'b0;
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
        end else begin
            r_bck_s1  <= audio_BCK;
            r_bck_s2  <= r_bck_s1;
            r_bck_s3  <= r_bck_s2;
            r_ws_s1   <= audio_WS;
            r_ws_s2   <= r_ws_s1;
            r_data_s1 <= audio_DATA;
            r_data_s2 <= r_data_s1;
        end
    end

    // Edge detection and next-count computation for the current BCK rise.
    // A WS change resets the counters before the capture decision so that
    // the transition edge itself is slot 0 of the new half-frame. If that
    // same edge was also the last capture slot of the old word, the old
    // word is finished with this edge's data instead of being flagged short.
    always_comb begin
        w_bck_rise   = r_bck_s2 & ~r_bck_s3;
        w_ws_edge    = w_bck_rise & r_ws_ref_ok & (r_ws_s2 != r_ws_prev);
        w_active     = r_locked | w_ws_edge;
        w_finish_old = w_ws_edge & r_locked &
                       (r_slot_cnt == SLOT_LAST) & (r_bit_cnt == BIT_LAST);
        w_slot_base  = w_ws_edge ? '0 : r_slot_cnt;
        w_bit_base   = w_ws_edge ? '0 : r_bit_cnt;
        w_capture    = w_bck_rise & w_active &
                       (w_slot_base == SLOT_LAST) & (w_bit_base < BIT_FULL);
        w_complete   = w_capture & (w_bit_base == BIT_LAST);
        w_short      = w_ws_edge & r_locked & (r_bit_cnt < BIT_FULL) & ~w_finish_old;
        w_slot_next  = (w_slot_base == SLOT_LAST) ? '0 : w_slot_base + SW'(1);
        w_bit_next   = w_capture ? w_bit_base + BW'(1) : w_bit_base;
    end

    // Deserialiser: counters, shift register and word/short-frame strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws_ref_ok <= 1'b0;
            r_ws_prev   <= 1'b0;
            r_locked    <= 1'b0;
            r_slot_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
            r_word_left <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_word_done <= w_complete | w_finish_old;
            r_word_left <= w_finish_old ? r_ws_prev : r_ws_s2;
            r_short     <= w_short;
            if (w_complete | w_finish_old) begin
                r_word <= {r_shift[WIDTH-2:0], r_data_s2};
            end
            if (w_bck_rise) begin
                r_ws_ref_ok <= 1'b1;
                r_ws_prev   <= r_ws_s2;
                r_locked    <= r_locked | w_ws_edge;
                if (w_active) begin
                    r_slot_cnt <= w_slot_next;
                    r_bit_cnt  <= w_bit_next;
                end
                if (w_capture) begin
                    r_shift <= {r_shift[WIDTH-2:0], r_data_s2};
                end
            end
        end
    end

    // Pair assembly: park right words, emit on a following complete left word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_right_hold    <= '0;
            r_right_ok      <= 1'b0;
            audio_out_left  <= '0;
            audio_out_right <= '0;
            sample_valid    <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (r_short) begin
                frame_err  <= 1'b1;
                r_right_ok <= 1'b0;
            end else if (r_word_done) begin
                if (!r_word_left) begin
                    r_right_hold <= r_word;
                    r_right_ok   <= 1'b1;
                end else if (r_right_ok) begin
                    audio_out_left  <= r_word;
                    audio_out_right <= r_right_hold;
                    sample_valid    <= 1'b1;
                    r_right_ok      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Bench for audio_i2s_receiver: directed frame table, hand-written reset
// sequences and randomised frames checked against a half-frame level model.

module tb_audio_i2s_receiver;

    localparam int W   = 16;
    localparam int SPB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic audio_BCK = 1'b0;
    logic audio_WS = 1'b0;
    logic audio_DATA = 1'b0;
    logic [W-1:0] audio_out_left;
    logic [W-1:0] audio_out_right;
    logic sample_valid;
    logic frame_err;

    audio_i2s_receiver #(.WIDTH(W), .SLOTS_PER_BIT(SPB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .audio_BCK       (audio_BCK),
        .audio_WS        (audio_WS),
        .audio_DATA      (audio_DATA),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right),
        .sample_valid    (sample_valid),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int hold_bad = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] l;
        logic [15:0] r;
    } ev_t;

    typedef struct {
        logic [31:0] rb;
        int          rn;
        logic [31:0] lb;
        int          ln;
        bit          e_err_r;
        bit          e_err_l;
        bit          e_val;
        logic [15:0] e_l;
        logic [15:0] e_r;
    } vec_t;

    typedef struct {
        bit          ws;
        int          n;
        logic [31:0] b;
    } half_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    logic [W-1:0] prev_l, prev_r;

    // Event monitor and hold-stability watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) got_q.push_back(ev_t'{1'b0, audio_out_left, audio_out_right});
            if (frame_err) got_q.push_back(ev_t'{1'b1, 16'h0, 16'h0});
            if (!sample_valid && (audio_out_left !== prev_l || audio_out_right !== prev_r))
                hold_bad <= hold_bad + 1;
        end
        prev_l <= audio_out_left;
        prev_r <= audio_out_right;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bck_cycle(input bit ws, input bit d, input int lo, input int hi, input bit lat);
        logic [3:0] pat;
        audio_BCK  = 1'b0;
        audio_WS   = ws;
        audio_DATA = d;
        wait_clk(lo);
        audio_BCK = 1'b1;
        if (lat) begin
            for (int i = 0; i < 4; i++) begin
                wait_clk(1);
                pat[i] = sample_valid;
            end
            chk("valid latency", {28'h0, pat}, 32'h8);
            wait_clk(hi - 4);
        end else begin
            wait_clk(hi);
        end
    endtask

    // rst_op: 0 none, 1 release rst_n before bit rst_bit, 2 pulse reset there.
    task automatic send_half(input bit ws, input int n, input logic [31:0] b, input int lo,
                             input int hi, input int rst_op, input int rst_bit, input bit lat);
        logic d;
        for (int k = 0; k < n; k++) begin
            d = b[n-1-k];
            if (k == rst_bit) begin
                if (rst_op == 1) begin
                    rst_n = 1'b1;
                end else if (rst_op == 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk("midreset left", {16'h0, audio_out_left}, 32'h0);
                    chk("midreset right", {16'h0, audio_out_right}, 32'h0);
                    chk("midreset valid", {31'h0, sample_valid}, 32'h0);
                    chk("midreset err", {31'h0, frame_err}, 32'h0);
                    wait_clk(3);
                    rst_n = 1'b1;
                end
            end
            for (int s = 0; s < SPB; s++)
                bck_cycle(ws, d, lo, hi, lat && (k == n - 1) && (s == SPB - 1));
        end
    endtask

    task automatic send_frame(input vec_t v, input bit lat);
        send_half(1'b0, v.rn, v.rb, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, v.ln, v.lb, 4, 4, 0, -1, lat);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        audio_BCK  = 1'b0;
        audio_WS   = 1'b0;
        audio_DATA = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic push_valid(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back(ev_t'{1'b0, l, r});
    endtask

    task automatic check_events(input string tag);
        int n;
        wait_clk(40);
        chk({tag, " event count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " kind"}, {31'h0, got_q[i].is_err}, {31'h0, exp_q[i].is_err});
            if (!exp_q[i].is_err) begin
                chk({tag, " left"}, {16'h0, got_q[i].l}, {16'h0, exp_q[i].l});
                chk({tag, " right"}, {16'h0, got_q[i].r}, {16'h0, exp_q[i].r});
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    localparam int NV = 11;
    vec_t tbl[NV];
    half_t hv[$];

    initial begin
        // rb/rn, lb/ln, err at right start, err at left start, valid, exp left, exp right
        tbl[0]  = vec_t'{32'h1234, 16, 32'hABCD, 16, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = vec_t'{32'h1234, 16, 32'hABCD, 16, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h1234};
        tbl[2]  = vec_t'{32'h1234, 16, 32'hABCD, 16, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h1234};
        tbl[3]  = vec_t'{32'h8001FF, 24, 32'h7FFEFF, 24, 1'b0, 1'b0, 1'b1, 16'h7FFE, 16'h8001};
        tbl[4]  = vec_t'{32'h1234, 16, 32'h02AF, 10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = vec_t'{32'h0000, 16, 32'hFFFF, 16, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000};
        tbl[6]  = vec_t'{32'h8000, 16, 32'h7FFF, 16, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h8000};
        tbl[7]  = vec_t'{32'hFFFF, 16, 32'h0000, 16, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
        tbl[8]  = vec_t'{32'h7FFF, 16, 32'h8000, 16, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF};
        tbl[9]  = vec_t'{32'h0A5A, 12, 32'h1111, 16, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = vec_t'{32'h1234, 16, 32'hABCD, 16, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h1234};

        // Reset state.
        wait_clk(3);
        chk("reset left", {16'h0, audio_out_left}, 32'h0);
        chk("reset right", {16'h0, audio_out_right}, 32'h0);
        chk("reset valid", {31'h0, sample_valid}, 32'h0);
        chk("reset err", {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Directed frame table.
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].e_err_r) exp_q.push_back(ev_t'{1'b1, 16'h0, 16'h0});
            if (tbl[i].e_err_l) exp_q.push_back(ev_t'{1'b1, 16'h0, 16'h0});
            if (tbl[i].e_val) push_valid(tbl[i].e_l, tbl[i].e_r);
            send_frame(tbl[i], i == 1);
        end
        check_events("table");

        // Reset released in the middle of a left half-frame.
        rst_n      = 1'b0;
        audio_BCK  = 1'b0;
        audio_WS   = 1'b0;
        wait_clk(4);
        send_half(1'b0, 16, 32'h5555, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'hAAAA, 4, 4, 1, 5, 1'b0);
        send_half(1'b0, 16, 32'h2222, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'hCCCC, 4, 4, 0, -1, 1'b0);
        send_half(1'b0, 16, 32'h0001, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'h8000, 4, 4, 0, -1, 1'b0);
        push_valid(16'hCCCC, 16'h2222);
        push_valid(16'h8000, 16'h0001);
        check_events("unlocked start");

        // Reset pulsed after 8 left bits.
        do_reset();
        send_half(1'b0, 16, 32'h1234, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'hABCD, 4, 4, 0, -1, 1'b0);
        send_half(1'b0, 16, 32'h1357, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'h2468, 4, 4, 0, -1, 1'b0);
        send_half(1'b0, 16, 32'h1111, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'h2222, 4, 4, 2, 8, 1'b0);
        send_half(1'b0, 16, 32'h0F0F, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'hF0F0, 4, 4, 0, -1, 1'b0);
        send_half(1'b0, 16, 32'h3C3C, 4, 4, 0, -1, 1'b0);
        send_half(1'b1, 16, 32'hC3C3, 4, 4, 0, -1, 1'b0);
        push_valid(16'h2468, 16'h1357);
        push_valid(16'hF0F0, 16'h0F0F);
        push_valid(16'hC3C3, 16'h3C3C);
        check_events("midframe reset");

        // Randomised half-frames against the half-frame level model.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 2; c++) begin
                half_t h;
                h.ws = c[0];
                h.n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 24)) : 16;
                h.b  = $urandom;
                hv.push_back(h);
            end
        end
        begin
            bit ok;
            logic [15:0] hold;
            logic [31:0] t;
            ok   = 1'b0;
            hold = 16'h0;
            // First half after reset only establishes WS; lock begins at hv[1].
            for (int i = 1; i < hv.size(); i++) begin
                if (hv[i].n >= 16) begin
                    t = hv[i].b >> (hv[i].n - 16);
                    if (!hv[i].ws) begin
                        hold = t[15:0];
                        ok   = 1'b1;
                    end else if (ok) begin
                        push_valid(t[15:0], hold);
                        ok = 1'b0;
                    end
                end else if (i < hv.size() - 1) begin
                    exp_q.push_back(ev_t'{1'b1, 16'h0, 16'h0});
                    ok = 1'b0;
                end
            end
        end
        foreach (hv[i])
            send_half(hv[i].ws, hv[i].n, hv[i].b, int'($urandom_range(3, 6)),
                      int'($urandom_range(3, 6)), 0, -1, 1'b0);
        check_events("random");

        chk("outputs stable between valids", hold_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
